prio_dec_dispatch: RTL



---
 rtl/prio_dec_dispatch_pkg.sv | 6 +
 rtl/prio_dec_dispatch_if.sv | 27 ++
 rtl/prio_dec_dispatch_dec.sv | 26 ++
 rtl/prio_dec_dispatch.sv | 54 +++++
 4 files changed

// File: rtl/prio_dec_dispatch_pkg.sv
// prio_dec_dispatch_pkg: shared switch constants (port count, descriptor and counter widths)
package prio_dec_dispatch_pkg;
  localparam int SW_NUM_PORTS = 16;
  localparam int PD_DATA_W_DEF = 32;
  localparam int PD_CNT_W_DEF = 16;
endpackage

// File: rtl/prio_dec_dispatch_if.sv
// prio_dec_dispatch_if: dispatch bus; in valid/ready/bin/data, one-hot out valid/ready + shared data, err_oor, drop_cnt
interface prio_dec_dispatch_if
  import prio_dec_dispatch_pkg::*;
#(
  parameter int W  = SW_NUM_PORTS,
  parameter int LW = $clog2(W),
  parameter int DW = PD_DATA_W_DEF,
  parameter int CW = PD_CNT_W_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_bin;
  logic [DW-1:0] in_data;
  logic [W-1:0]  out_valid;
  logic [W-1:0]  out_ready;
  logic [DW-1:0] out_data;
  logic          err_oor;
  logic [CW-1:0] drop_cnt;
  modport master (
    output in_valid, in_bin, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_oor, drop_cnt
  );
  modport slave (
    input  in_valid, in_bin, in_data, out_ready,
    output in_ready, out_valid, out_data, err_oor, drop_cnt
  );
endinterface

// File: rtl/prio_dec_dispatch_dec.sv
// prio_dec: binary-tree index-to-one-hot decoder; en, bin in; onehot, in_range, oor out
module prio_dec
  import prio_dec_dispatch_pkg::*;
#(
  parameter int W  = SW_NUM_PORTS,
  parameter int LW = $clog2(W)
) (
  input  logic          en,
  input  logic [LW-1:0] bin,
  output logic [W-1:0]  onehot,
  output logic          in_range,
  output logic          oor
);
  localparam int N = 1 << LW;
  logic [2*N-1:1] t;
  logic [N-1:0] leaves;
  assign t[1] = en;
  for (genvar n = 2; n < 2 * N; n++) begin : g_node
    localparam int D = $clog2(n + 1) - 1;
    assign t[n] = t[n/2] & ((n % 2 == 1) ? bin[LW-D] : ~bin[LW-D]);
  end
  assign leaves = t[2*N-1:N];
  assign onehot = leaves[W-1:0];
  assign in_range = |onehot;
  assign oor = |leaves & ~in_range;
endmodule

// File: rtl/prio_dec_dispatch.sv
// prio_dec_dispatch: decodes port index to one-hot valid with 2-entry skid buffer; clk, rst, bus (slave)
module prio_dec_dispatch
  import prio_dec_dispatch_pkg::*;
#(
  parameter int PD_WIDTH    = SW_NUM_PORTS,
  parameter int PD_WIDTH_L2 = $clog2(PD_WIDTH),
  parameter int PD_DATA_W   = PD_DATA_W_DEF,
  parameter int PD_CNT_W    = PD_CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  prio_dec_dispatch_if.slave bus
);
  logic [PD_WIDTH-1:0] o_hot, s_hot, dec_hot;
  logic [PD_DATA_W-1:0] o_data, s_data;
  logic [PD_CNT_W-1:0] drop_cnt;
  logic take, hit, oor, drn, o_full, s_full, err_oor;
  assign o_full = |o_hot;
  assign s_full = |s_hot;
  assign take = bus.in_valid && !s_full;
  assign drn = |(o_hot & bus.out_ready);
  prio_dec #(.W(PD_WIDTH), .LW(PD_WIDTH_L2)) u_dec (
    .en(take), .bin(bus.in_bin), .onehot(dec_hot), .in_range(hit), .oor(oor)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      o_hot <= '0;
      s_hot <= '0;
      o_data <= '0;
      s_data <= '0;
      err_oor <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_oor <= oor;
      if (oor && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (drn && s_full) begin
        o_hot <= s_hot;
        o_data <= s_data;
        s_hot <= '0;
      end else if (!o_full || drn) begin
        o_hot <= dec_hot;
        if (hit) o_data <= bus.in_data;
      end else if (hit) begin
        s_hot <= dec_hot;
        s_data <= bus.in_data;
      end
    end
  end
  assign bus.in_ready = !s_full;
  assign bus.out_valid = o_hot;
  assign bus.out_data = o_data;
  assign bus.err_oor = err_oor;
  assign bus.drop_cnt = drop_cnt;
endmodule
